// File: rtl/irqsched_pkg.sv
// Shared privileged-unit definitions for the interrupt scheduler: cause codes,
// privilege encodings and scheduler FSM states.
package irqsched_pkg;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_SEI = 4'd9;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_STI = 4'd5;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_SSI = 4'd1;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Only the six standard interrupt sources take part in scheduling.
    localparam logic [11:0] IRQ_MASK = 12'hAAA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BLANK = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irqsched_irqprio.sv
// Fixed-priority encoder over an eligible-interrupt vector:
// MEI > MSI > MTI > SEI > SSI > STI.
module irqprio
    import irqsched_pkg::*;
(
    input  logic [11:0] elig_i,
    output logic        valid_o,
    output logic [3:0]  cause_o
);

    // Priority chain; the bit index of each source equals its cause code.
    always_comb begin
        valid_o = 1'b1;
        cause_o = 4'd0;
        if (elig_i[CAUSE_MEI]) begin
            cause_o = CAUSE_MEI;
        end else if (elig_i[CAUSE_MSI]) begin
            cause_o = CAUSE_MSI;
        end else if (elig_i[CAUSE_MTI]) begin
            cause_o = CAUSE_MTI;
        end else if (elig_i[CAUSE_SEI]) begin
            cause_o = CAUSE_SEI;
        end else if (elig_i[CAUSE_SSI]) begin
            cause_o = CAUSE_SSI;
        end else if (elig_i[CAUSE_STI]) begin
            cause_o = CAUSE_STI;
        end else begin
            valid_o = 1'b0;
            cause_o = 4'd0;
        end
    end

endmodule

// File: rtl/irqsched.sv
// Interrupt scheduler: registers interrupt state, picks the highest-priority
// takeable interrupt and holds it as a trap request until acknowledged.
module irqsched
    import irqsched_pkg::*;
#(
    parameter bit S_SUPPORTED = 1'b1,
    parameter bit U_SUPPORTED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] MIP,
    input  logic [11:0] MIE,
    input  logic [11:0] MIDELEG,
    input  logic        STATUS_MIE,
    input  logic        STATUS_SIE,
    input  logic [1:0]  PrivilegeModeW,
    input  logic        IntAckM,
    output logic        IntReqM,
    output logic [3:0]  IntCauseM,
    output logic        IntDelegateM,
    output logic        WakeM
);

    logic [11:0] mip_q, mie_q, mideleg_q;
    logic        status_mie_q, status_sie_q;
    logic [1:0]  priv_q;

    irq_state_e  state_q, state_d;
    logic [3:0]  cause_q, cause_d;
    logic        deleg_q, deleg_d;
    logic        req_q, req_d;
    logic        wake_q, wake_d;

    logic [11:0] pend_s, deleg_mask_s, m_elig_s, s_elig_s;
    logic [1:0]  priv_s;
    logic        m_en_s, s_en_s;
    logic        m_valid_s, s_valid_s, win_valid_s, win_deleg_s;
    logic [3:0]  m_cause_s, s_cause_s, win_cause_s;

    // Input capture stage; eligibility is always judged on these copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mip_q        <= 12'd0;
            mie_q        <= 12'd0;
            mideleg_q    <= 12'd0;
            status_mie_q <= 1'b0;
            status_sie_q <= 1'b0;
            priv_q       <= PRIV_U;
        end else begin
            mip_q        <= MIP;
            mie_q        <= MIE;
            mideleg_q    <= MIDELEG;
            status_mie_q <= STATUS_MIE;
            status_sie_q <= STATUS_SIE;
            priv_q       <= PrivilegeModeW;
        end
    end

    // Split pending interrupts into M-level and S-level eligible sets.
    always_comb begin
        priv_s       = U_SUPPORTED ? priv_q : PRIV_M;
        pend_s       = mip_q & mie_q & IRQ_MASK;
        deleg_mask_s = S_SUPPORTED ? mideleg_q : 12'd0;
        m_en_s       = (priv_s != PRIV_M) || status_mie_q;
        s_en_s       = (priv_s == PRIV_U) || ((priv_s == PRIV_S) && status_sie_q);
        m_elig_s     = pend_s & ~deleg_mask_s & {12{m_en_s}};
        s_elig_s     = pend_s & deleg_mask_s & {12{s_en_s}};
    end

    irqprio u_prio_m (
        .elig_i  (m_elig_s),
        .valid_o (m_valid_s),
        .cause_o (m_cause_s)
    );

    irqprio u_prio_s (
        .elig_i  (s_elig_s),
        .valid_o (s_valid_s),
        .cause_o (s_cause_s)
    );

    // Any M-level winner beats every S-level one.
    always_comb begin
        if (m_valid_s) begin
            win_valid_s = 1'b1;
            win_cause_s = m_cause_s;
            win_deleg_s = 1'b0;
        end else if (s_valid_s) begin
            win_valid_s = 1'b1;
            win_cause_s = s_cause_s;
            win_deleg_s = 1'b1;
        end else begin
            win_valid_s = 1'b0;
            win_cause_s = 4'd0;
            win_deleg_s = 1'b0;
        end
    end

    // Request FSM; an ack always wins over input changes while in REQ.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        deleg_d = deleg_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_d = ST_REQ;
                    cause_d = win_cause_s;
                    deleg_d = win_deleg_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (IntAckM) begin
                    state_d = ST_BLANK;
                end else if (!win_valid_s) begin
                    state_d = ST_IDLE;
                end else if ((win_cause_s != cause_q) || (win_deleg_s != deleg_q)) begin
                    state_d = ST_REQ;
                    cause_d = win_cause_s;
                    deleg_d = win_deleg_s;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_BLANK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_REQ);
        wake_d = |(MIP & MIE & IRQ_MASK);
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= 4'd0;
            deleg_q <= 1'b0;
            req_q   <= 1'b0;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            deleg_q <= deleg_d;
            req_q   <= req_d;
            wake_q  <= wake_d;
        end
    end

    assign IntReqM      = req_q;
    assign IntCauseM    = cause_q;
    assign IntDelegateM = deleg_q;
    assign WakeM        = wake_q;

endmodule

// File: tb/tb_irqsched.sv
// Directed self-checking bench for irqsched: one task per scenario, each with
// hand-computed expected request/cause/delegate/wake values.
module tb_irqsched;

    logic        clk;
    logic        reset;
    logic [11:0] MIP, MIE, MIDELEG;
    logic        STATUS_MIE, STATUS_SIE;
    logic [1:0]  PrivilegeModeW;
    logic        IntAckM;
    logic        IntReqM;
    logic [3:0]  IntCauseM;
    logic        IntDelegateM;
    logic        WakeM;

    int total = 0;
    int bad   = 0;

    irqsched dut (
        .clk            (clk),
        .reset          (reset),
        .MIP            (MIP),
        .MIE            (MIE),
        .MIDELEG        (MIDELEG),
        .STATUS_MIE     (STATUS_MIE),
        .STATUS_SIE     (STATUS_SIE),
        .PrivilegeModeW (PrivilegeModeW),
        .IntAckM        (IntAckM),
        .IntReqM        (IntReqM),
        .IntCauseM      (IntCauseM),
        .IntDelegateM   (IntDelegateM),
        .WakeM          (WakeM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiesce();
        MIP = 12'd0; MIE = 12'd0; MIDELEG = 12'd0;
        STATUS_MIE = 1'b0; STATUS_SIE = 1'b0;
        PrivilegeModeW = 2'b11; IntAckM = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MIP = 12'd0; MIE = 12'd0; MIDELEG = 12'd0;
        STATUS_MIE = 1'b0; STATUS_SIE = 1'b0;
        PrivilegeModeW = 2'b11; IntAckM = 1'b0;
        #3;
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM, WakeM} !== 7'd0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b cause=%0d deleg=%b wake=%b, want all 0",
                     IntReqM, IntCauseM, IntDelegateM, WakeM);
        end
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_m_mode_ack();
        PrivilegeModeW = 2'b11; STATUS_MIE = 1'b1;
        MIP = 12'h080; MIE = 12'h080;
        tick(1);
        total++;
        if (IntReqM !== 1'b0) begin
            bad++; $display("FAIL m_latency_early: req=%b want 0", IntReqM);
        end
        tick(1);
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b1, 4'd7, 1'b0}) begin
            bad++; $display("FAIL m_req: req=%b cause=%0d deleg=%b want 1/7/0", IntReqM, IntCauseM, IntDelegateM);
        end
        IntAckM = 1'b1;
        tick(1);
        IntAckM = 1'b0;
        total++;
        if ({IntReqM, IntCauseM} !== {1'b0, 4'd7}) begin
            bad++; $display("FAIL m_blank: req=%b cause=%0d want 0/7", IntReqM, IntCauseM);
        end
        tick(1);
        total++;
        if (IntReqM !== 1'b0) begin
            bad++; $display("FAIL m_gap: req=%b want 0", IntReqM);
        end
        tick(1);
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b1, 4'd7, 1'b0}) begin
            bad++; $display("FAIL m_rereq: req=%b cause=%0d deleg=%b want 1/7/0", IntReqM, IntCauseM, IntDelegateM);
        end
        // Global MIE off in M-mode: request retracted, wake stays.
        STATUS_MIE = 1'b0;
        tick(2);
        total++;
        if ({IntReqM, WakeM} !== 2'b01) begin
            bad++; $display("FAIL m_global_off: req=%b wake=%b want 0/1", IntReqM, WakeM);
        end
        quiesce();
    endtask

    task automatic test_delegation();
        PrivilegeModeW = 2'b00;
        MIP = 12'h082; MIE = 12'h082; MIDELEG = 12'h002;
        tick(2);
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b1, 4'd7, 1'b0}) begin
            bad++; $display("FAIL deleg_m_wins: req=%b cause=%0d deleg=%b want 1/7/0", IntReqM, IntCauseM, IntDelegateM);
        end
        MIP = 12'h002;
        tick(1);
        total++;
        if ({IntReqM, IntCauseM} !== {1'b1, 4'd7}) begin
            bad++; $display("FAIL deleg_hold: req=%b cause=%0d want 1/7", IntReqM, IntCauseM);
        end
        tick(1);
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b1, 4'd1, 1'b1}) begin
            bad++; $display("FAIL deleg_reload: req=%b cause=%0d deleg=%b want 1/1/1", IntReqM, IntCauseM, IntDelegateM);
        end
        quiesce();
    endtask

    task automatic test_s_level();
        PrivilegeModeW = 2'b11; STATUS_MIE = 1'b1; STATUS_SIE = 1'b1;
        MIP = 12'h200; MIE = 12'h200; MIDELEG = 12'h200;
        tick(3);
        total++;
        if ({IntReqM, WakeM} !== 2'b01) begin
            bad++; $display("FAIL s_in_m_mode: req=%b wake=%b want 0/1", IntReqM, WakeM);
        end
        PrivilegeModeW = 2'b01;
        tick(1);
        total++;
        if (IntReqM !== 1'b0) begin
            bad++; $display("FAIL s_latency_early: req=%b want 0", IntReqM);
        end
        tick(1);
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b1, 4'd9, 1'b1}) begin
            bad++; $display("FAIL s_req: req=%b cause=%0d deleg=%b want 1/9/1", IntReqM, IntCauseM, IntDelegateM);
        end
        // SIE off in S-mode retracts an S-level request.
        STATUS_SIE = 1'b0;
        tick(2);
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b0, 4'd9, 1'b1}) begin
            bad++; $display("FAIL s_sie_off: req=%b cause=%0d deleg=%b want 0/9/1", IntReqM, IntCauseM, IntDelegateM);
        end
        quiesce();
    endtask

    task automatic test_priority();
        logic [3:0]  order [6];
        logic [11:0] pend;
        order[0] = 4'd11; order[1] = 4'd3; order[2] = 4'd7;
        order[3] = 4'd9;  order[4] = 4'd1; order[5] = 4'd5;
        pend = 12'hAAA;
        PrivilegeModeW = 2'b00;
        MIP = pend; MIE = 12'hFFF; MIDELEG = 12'h000;
        for (int i = 0; i < 6; i++) begin
            tick(2);
            total++;
            if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b1, order[i], 1'b0}) begin
                bad++; $display("FAIL prio_step%0d: req=%b cause=%0d deleg=%b want 1/%0d/0",
                                i, IntReqM, IntCauseM, IntDelegateM, order[i]);
            end
            pend[order[i]] = 1'b0;
            MIP = pend;
        end
        tick(2);
        total++;
        if ({IntReqM, IntCauseM, WakeM} !== {1'b0, 4'd5, 1'b0}) begin
            bad++; $display("FAIL prio_empty: req=%b cause=%0d wake=%b want 0/5/0", IntReqM, IntCauseM, WakeM);
        end
        quiesce();
    endtask

    task automatic test_retraction();
        PrivilegeModeW = 2'b00;
        MIP = 12'h080; MIE = 12'h080;
        tick(2);
        MIE = 12'h000;
        tick(1);
        total++;
        if (IntReqM !== 1'b1) begin
            bad++; $display("FAIL retract_early: req=%b want 1", IntReqM);
        end
        tick(1);
        total++;
        if ({IntReqM, IntCauseM, WakeM} !== {1'b0, 4'd7, 1'b0}) begin
            bad++; $display("FAIL retract: req=%b cause=%0d wake=%b want 0/7/0", IntReqM, IntCauseM, WakeM);
        end
        // Ack together with input removal: ack wins, request drops immediately.
        MIE = 12'h008; MIP = 12'h008;
        tick(2);
        MIE = 12'h000; IntAckM = 1'b1;
        tick(1);
        IntAckM = 1'b0;
        total++;
        if ({IntReqM, IntCauseM} !== {1'b0, 4'd3}) begin
            bad++; $display("FAIL ack_with_removal: req=%b cause=%0d want 0/3", IntReqM, IntCauseM);
        end
        quiesce();
    endtask

    task automatic test_reset_mid_req();
        PrivilegeModeW = 2'b00;
        MIP = 12'h800; MIE = 12'h800;
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM, WakeM} !== 7'd0) begin
            bad++; $display("FAIL reset_mid_req: req=%b cause=%0d deleg=%b wake=%b want all 0",
                            IntReqM, IntCauseM, IntDelegateM, WakeM);
        end
        #1;
        reset = 1'b0;
        tick(1);
        total++;
        if ({IntReqM, WakeM} !== 2'b01) begin
            bad++; $display("FAIL post_reset_early: req=%b wake=%b want 0/1", IntReqM, WakeM);
        end
        tick(1);
        total++;
        if ({IntReqM, IntCauseM, IntDelegateM} !== {1'b1, 4'd11, 1'b0}) begin
            bad++; $display("FAIL post_reset_req: req=%b cause=%0d deleg=%b want 1/11/0", IntReqM, IntCauseM, IntDelegateM);
        end
        quiesce();
    endtask

    initial begin
        test_reset();
        test_m_mode_ack();
        test_delegation();
        test_s_level();
        test_priority();
        test_retraction();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
